instr_fetch: RTL and testbench

Instruction fetch unit sitting between the program counter and the instruction memory port. It consumes the PC's current fetch address, issues a held-until-hit read to instruction memory, tells the PC when to advance, and buffers fetched words with their next-PC in a 2-entry queue. Decode drains that queue through a valid/ready handshake. A taken branch or jump flushes the queue and discards any in-flight result.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/instr_fetch_if.sv | 35 +++
 rtl/fetch_queue.sv | 64 ++++++
 rtl/instr_fetch.sv | 86 ++++++++
 tb/tb_instr_fetch.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU front-end types: machine word, fetch FSM states and the
// fetch queue entry carried from instruction fetch to decode.
package cpu_types_pkg;

  localparam int ADDR_W = 32;

  typedef logic [ADDR_W-1:0] word_t;

  // Fetch FSM states
  //   IDLE | no request outstanding; launches when the queue has room
  //   REQ  | read held on the memory port, result will be kept
  //   DROP | read held on the memory port, result will be thrown away
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
  } fetch_entry_t;

  localparam word_t PC_INC = 32'd4;

  // Sequential next-PC; 32-bit wrap-around is intended.
  function automatic word_t next_pc(input word_t addr, input word_t inc);
    return addr + inc;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus: PC handshake, instruction memory port and the
// valid/ready link to decode, bundled so the environment connects once.
interface instr_fetch_if;
  import cpu_types_pkg::*;

  // program counter side
  word_t imemaddr;
  logic  pc_en;
  logic  flush;

  // instruction memory side
  logic  iREN;
  word_t iaddr;
  logic  ihit;
  word_t iload;

  // decode side
  word_t instr_out;
  word_t npc_out;
  logic  valid_out;
  logic  ready_in;

  // fetch unit view
  modport master (
    input  imemaddr, flush, ihit, iload, ready_in,
    output pc_en, iREN, iaddr, instr_out, npc_out, valid_out
  );

  // environment view (PC, memory, decode)
  modport slave (
    output imemaddr, flush, ihit, iload, ready_in,
    input  pc_en, iREN, iaddr, instr_out, npc_out, valid_out
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry circular buffer of fetched words. A clear wins over any
// push or pop in the same cycle; the head reads zero when empty so
// decode never sees a stale entry.
module fetch_queue
  import cpu_types_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clr_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o,
  output logic         empty_o,
  output logic         full_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  logic do_push;
  logic do_pop;

  // status flags and qualified push/pop
  always_comb begin
    empty_o = (count_q == 2'd0);
    full_o  = (count_q == 2'd2);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    count_o = count_q;
    head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  end

  // pointer and occupancy update
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // entry storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (do_push && !clr_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: launches one held read at a time, advances
// the PC on each kept hit, and queues {instr, npc} for decode. A flush
// empties the queue and turns an unfinished read into a drop.
module instr_fetch #(
  parameter int unsigned DEPTH  = 2,
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic          CLK,
  input  logic          RST,
  instr_fetch_if.master bus
);
  import cpu_types_pkg::*;

  fetch_state_t state_q;
  word_t        req_addr_q;

  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic [1:0]   count;
  logic         q_empty;
  logic         q_full;
  logic         push;
  logic         pop;
  logic         room;

  // only a two-entry queue exists, so room means fewer than DEPTH entries
  assign room = (count < 2'(DEPTH)) && !q_full;

  // request FSM; memory needs a started read to complete, so a flush
  // during a wait parks in DROP until the hit arrives
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!bus.flush && room) begin
            state_q    <= REQ;
            req_addr_q <= bus.imemaddr;
          end
        end
        REQ: begin
          if (bus.ihit)       state_q <= IDLE;
          else if (bus.flush) state_q <= DROP;
        end
        DROP: begin
          if (bus.ihit) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // memory port, PC strobe and queue controls
  always_comb begin
    bus.iREN         = (state_q == REQ) || (state_q == DROP);
    bus.iaddr        = bus.iREN ? req_addr_q : '0;
    push             = (state_q == REQ) && bus.ihit && !bus.flush;
    bus.pc_en        = push;
    push_entry.instr = bus.iload;
    push_entry.npc   = next_pc(req_addr_q, PC_INC);
  end

  // decode handshake
  always_comb begin
    bus.valid_out = !q_empty;
    pop           = bus.valid_out && bus.ready_in;
    bus.instr_out = head.instr;
    bus.npc_out   = head.npc;
  end

  fetch_queue u_fetch_queue (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (bus.flush),
    .din_i   (push_entry),
    .head_o  (head),
    .count_o (count),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios drive the PC/memory side,
// expected queue entries go into a scoreboard, and a negedge monitor
// checks every decode handshake against it.
module tb_instr_fetch;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  instr_fetch_if bus();

  instr_fetch #(.DEPTH(2), .PC_INC(32'd4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hits   = 0;
  int n_pcen   = 0;
  fetch_entry_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // monitor: decode handshakes against the scoreboard
  always @(negedge CLK) begin
    fetch_entry_t e;
    if (!RST) begin
      if (bus.pc_en) n_pcen++;
      check("valid_out", {31'b0, bus.valid_out}, {31'b0, exp_q.size() != 0});
      if (bus.valid_out && bus.ready_in && !bus.flush) begin
        if (exp_q.size() == 0) begin
          check("unexpected pop", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("instr_out", bus.instr_out, e.instr);
          check("npc_out", bus.npc_out, e.npc);
        end
      end else if (!bus.valid_out) begin
        check("empty instr_out", bus.instr_out, 32'h0);
        check("empty npc_out", bus.npc_out, 32'h0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, " iREN"},      {31'b0, bus.iREN},      32'h0);
    check({tag, " iaddr"},     bus.iaddr,              32'h0);
    check({tag, " pc_en"},     {31'b0, bus.pc_en},     32'h0);
    check({tag, " valid_out"}, {31'b0, bus.valid_out}, 32'h0);
    check({tag, " instr_out"}, bus.instr_out,          32'h0);
    check({tag, " npc_out"},   bus.npc_out,            32'h0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.flush = 1'b0;
    bus.ihit = 1'b0;
    bus.iload = '0;
    tick();
    tick();
    check_all_zero("reset");
    exp_q.delete();
    RST = 1'b0;
  endtask

  task automatic wait_iren();
    int w = 0;
    while (!bus.iREN && w < 20) begin
      tick();
      w++;
    end
    check("iREN launch", {31'b0, bus.iREN}, 32'h1);
  endtask

  // one kept fetch at the bench PC, hit after lat wait cycles
  task automatic serve(input int lat);
    fetch_entry_t pend;
    wait_iren();
    check("iaddr", bus.iaddr, bus.imemaddr);
    for (int k = 0; k < lat; k++) begin
      #1 check("pc_en idle wait", {31'b0, bus.pc_en}, 32'h0);
      tick();
      check("iREN held", {31'b0, bus.iREN}, 32'h1);
      check("iaddr held", bus.iaddr, bus.imemaddr);
    end
    bus.ihit = 1'b1;
    bus.iload = bus.imemaddr ^ 32'hDEAD_BEEF;
    #1 check("pc_en on hit", {31'b0, bus.pc_en}, 32'h1);
    pend.instr = bus.iload;
    pend.npc   = bus.imemaddr + 32'd4;
    n_hits++;
    tick();
    bus.ihit = 1'b0;
    bus.iload = '0;
    exp_q.push_back(pend);
    bus.imemaddr = bus.imemaddr + 32'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    bus.imemaddr = '0;
    bus.flush = 1'b0;
    bus.ihit = 1'b0;
    bus.iload = '0;
    bus.ready_in = 1'b0;

    // reset then steady fetch
    do_reset();
    bus.imemaddr = 32'h0;
    bus.ready_in = 1'b1;
    serve(1);
    check("first instr", bus.instr_out, 32'hDEAD_BEEF);
    check("first npc", bus.npc_out, 32'h0000_0004);
    for (int i = 1; i < 8; i++) serve(i % 2);
    repeat (3) tick();

    // backpressure
    do_reset();
    bus.imemaddr = 32'h0;
    bus.ready_in = 1'b0;
    serve(0);
    serve(0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("full iREN", {31'b0, bus.iREN}, 32'h0);
    end
    bus.ready_in = 1'b1;
    check("bp head npc", bus.npc_out, 32'h0000_0004);
    tick();
    bus.ready_in = 1'b0;
    check("bp no launch yet", {31'b0, bus.iREN}, 32'h0);
    tick();
    check("bp launch", {31'b0, bus.iREN}, 32'h1);
    check("bp iaddr", bus.iaddr, 32'h0000_0008);
    serve(0);
    bus.ready_in = 1'b1;
    repeat (4) tick();

    // flush during wait, then drop
    do_reset();
    bus.ready_in = 1'b0;
    bus.imemaddr = 32'h0000_000C;
    serve(0);
    wait_iren();
    check("pre-flush iaddr", bus.iaddr, 32'h0000_0010);
    bus.flush = 1'b1;
    #1 check("flush wait pc_en", {31'b0, bus.pc_en}, 32'h0);
    tick();
    bus.flush = 1'b0;
    bus.imemaddr = 32'h0000_0040;
    exp_q.delete();
    check("drop iREN", {31'b0, bus.iREN}, 32'h1);
    check("drop iaddr", bus.iaddr, 32'h0000_0010);
    check("drop valid_out", {31'b0, bus.valid_out}, 32'h0);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("drop iREN 2", {31'b0, bus.iREN}, 32'h1);
    check("drop iaddr 2", bus.iaddr, 32'h0000_0010);
    bus.ihit = 1'b1;
    bus.iload = 32'h0BAD_0BAD;
    #1 check("drop hit pc_en", {31'b0, bus.pc_en}, 32'h0);
    tick();
    bus.ihit = 1'b0;
    bus.iload = '0;
    check("after drop iREN", {31'b0, bus.iREN}, 32'h0);
    bus.ready_in = 1'b1;
    serve(0);
    check("post-flush npc", bus.npc_out, 32'h0000_0044);
    repeat (2) tick();

    // flush coincident with hit and pop
    do_reset();
    bus.ready_in = 1'b0;
    bus.imemaddr = 32'h0000_0020;
    serve(0);
    wait_iren();
    check("coinc iaddr", bus.iaddr, 32'h0000_0024);
    bus.ihit = 1'b1;
    bus.iload = 32'h1234_5678;
    bus.ready_in = 1'b1;
    bus.flush = 1'b1;
    #1 check("coinc pc_en", {31'b0, bus.pc_en}, 32'h0);
    check("coinc valid", {31'b0, bus.valid_out}, 32'h1);
    tick();
    bus.ihit = 1'b0;
    bus.iload = '0;
    bus.flush = 1'b0;
    exp_q.delete();
    bus.imemaddr = 32'h0000_0080;
    check("coinc emptied", {31'b0, bus.valid_out}, 32'h0);
    check("coinc idle", {31'b0, bus.iREN}, 32'h0);
    tick();
    check("coinc relaunch", {31'b0, bus.iREN}, 32'h1);
    check("coinc new iaddr", bus.iaddr, 32'h0000_0080);
    serve(0);
    repeat (2) tick();

    // reset mid-request
    do_reset();
    bus.ready_in = 1'b1;
    bus.imemaddr = 32'h0000_0100;
    wait_iren();
    check("mid iaddr", bus.iaddr, 32'h0000_0100);
    RST = 1'b1;
    #1 check("mid pc_en", {31'b0, bus.pc_en}, 32'h0);
    tick();
    RST = 1'b0;
    exp_q.delete();
    bus.ihit = 1'b1;
    bus.iload = 32'hFACE_FACE;
    #1 check_all_zero("mid reset");
    tick();
    bus.ihit = 1'b0;
    bus.iload = '0;
    check("mid relaunch", {31'b0, bus.iREN}, 32'h1);
    check("mid no push", {31'b0, bus.valid_out}, 32'h0);
    serve(1);
    repeat (2) tick();

    // npc wrap-around
    do_reset();
    bus.ready_in = 1'b1;
    bus.imemaddr = 32'hFFFF_FFFC;
    serve(0);
    check("wrap npc", bus.npc_out, 32'h0000_0000);
    check("wrap instr", bus.instr_out, 32'h2152_4113);
    repeat (2) tick();

    check("pc_en pulses", n_pcen, n_hits);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
